line_scheduler: RTL and testbench

- Sequences display of the angular line slots in each revolution.
- Measures revolution period from the frame opto, divides it into LINES equal slots, and fires one line-display command per slot to the TLC shift/latch engine.
- Owns the Pi-facing flow control: busy_o_pi and frame_rst_o_pi, which gate burst writes of FIFO_LINES lines into the line FIFO.
- Sits between the SMI write path/line FIFO and the TLC driver inside top.

---
 rtl/spin_pkg.sv | 18 +
 rtl/line_scheduler_period_meter.sv | 78 +++++++
 rtl/line_scheduler.sv | 171 +++++++++++++++++
 tb/tb_line_scheduler.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spin_pkg.sv
// Shared constants and types for the POV display line path.
package spin_pkg;
  localparam int LINES      = 256;
  localparam int FIFO_LINES = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int LEDS       = 16;
  localparam int PERIOD_W   = 24;
  localparam int LOG2_LINES = $clog2(LINES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } sched_state_t;

  typedef logic [LOG2_LINES-1:0] line_idx_t;
  typedef logic [PERIOD_W-1:0]   period_t;
endpackage

// File: rtl/line_scheduler_period_meter.sv
// Opto synchronizer, frame tick, revolution counter and slot length capture.
// With LINE_SCHED_STATS_EN the captured period is also exported.
module period_meter #(
  parameter int LINES    = spin_pkg::LINES,
  parameter int PERIOD_W = spin_pkg::PERIOD_W
) (
  input  logic                clk_i,
  input  logic                global_rst,
  input  logic                frame_opto_i,
  output logic                frame_tick_o,
  output logic [PERIOD_W-1:0] slot_len_o,
`ifdef LINE_SCHED_STATS_EN
  output logic [PERIOD_W-1:0] period_o,
`endif
  output logic                timeout_o
);
  localparam int LOG2 = $clog2(LINES);
  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

  logic [2:0]          sync_q, sync_d;
  logic                tick_q, tick_d;
  logic [PERIOD_W-1:0] rev_cnt_q, rev_cnt_d;
  logic [PERIOD_W-1:0] slot_len_q, slot_len_d;
`ifdef LINE_SCHED_STATS_EN
  logic [PERIOD_W-1:0] period_q, period_d;
`endif

  // Next-state: sync chain, edge detect, saturating revolution count and capture.
  // The counter restarts at 1 so the captured value equals the tick-to-tick interval.
  always_comb begin
    sync_d     = {sync_q[1:0], frame_opto_i};
    tick_d     = sync_q[1] & ~sync_q[2];
    slot_len_d = slot_len_q;
`ifdef LINE_SCHED_STATS_EN
    period_d   = period_q;
`endif
    if (tick_q) begin
      rev_cnt_d  = PERIOD_W'(1);
      slot_len_d = rev_cnt_q >> LOG2;
`ifdef LINE_SCHED_STATS_EN
      period_d   = rev_cnt_q;
`endif
    end else if (rev_cnt_q != CNT_MAX) begin
      rev_cnt_d = rev_cnt_q + PERIOD_W'(1);
    end else begin
      rev_cnt_d = rev_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (global_rst) begin
      sync_q     <= 3'b000;
      tick_q     <= 1'b0;
      rev_cnt_q  <= '0;
      slot_len_q <= '0;
`ifdef LINE_SCHED_STATS_EN
      period_q   <= '0;
`endif
    end else begin
      sync_q     <= sync_d;
      tick_q     <= tick_d;
      rev_cnt_q  <= rev_cnt_d;
      slot_len_q <= slot_len_d;
`ifdef LINE_SCHED_STATS_EN
      period_q   <= period_d;
`endif
    end
  end

  // On the tick cycle the freshly measured slot length is forwarded directly.
  assign slot_len_o   = tick_q ? (rev_cnt_q >> LOG2) : slot_len_q;
  assign frame_tick_o = tick_q;
  assign timeout_o    = (rev_cnt_q == CNT_MAX);
`ifdef LINE_SCHED_STATS_EN
  assign period_o     = period_q;
`endif
endmodule

// File: rtl/line_scheduler.sv
// Per-revolution line slot sequencer and Pi write flow control.
// Optional LINE_SCHED_STATS_EN adds underrun/late counters and the measured period.
module line_scheduler import spin_pkg::*; #(
  parameter int LINES      = spin_pkg::LINES,
  parameter int FIFO_LINES = spin_pkg::FIFO_LINES,
  parameter int FIFO_DEPTH = spin_pkg::FIFO_DEPTH,
  parameter int PERIOD_W   = spin_pkg::PERIOD_W
) (
  input  logic                             clk_i,
  input  logic                             global_rst,
  input  logic                             frame_opto_i,
  input  logic                             line_wr_i,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_i,
  input  logic                             tlc_busy_i,
  output logic                             line_go_o,
  output logic [$clog2(LINES)-1:0]         line_idx_o,
  output logic                             blank_o,
  output logic                             fifo_flush_o,
  output logic                             frame_rst_o_pi,
`ifdef LINE_SCHED_STATS_EN
  output logic [15:0]                      underrun_cnt_o,
  output logic [15:0]                      late_cnt_o,
  output logic [PERIOD_W-1:0]              period_o,
`endif
  output logic                             busy_o_pi
);
  localparam int IDX_W = $clog2(LINES);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int LW_W  = $clog2(LINES+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES-1);
  localparam logic [LW_W-1:0]  LW_FULL  = LW_W'(LINES);
  localparam logic [LVL_W-1:0] LVL_HI   = LVL_W'(FIFO_DEPTH-FIFO_LINES);

  logic                frame_tick, timeout;
  logic [PERIOD_W-1:0] slot_len, slot_reload;
  logic                fifo_empty;
  sched_state_t        state_q, state_d;
  logic [PERIOD_W-1:0] slot_timer_q, slot_timer_d;
  logic [IDX_W-1:0]    line_idx_q, line_idx_d;
  logic [LW_W-1:0]     lines_written_q, lines_written_d;
  logic decide_q, decide_d, line_go_q, line_go_d, flush_q, flush_d;
  logic frame_rst_q, frame_rst_d, busy_q, busy_d, blank_q, blank_d;

`ifdef LINE_SCHED_STATS_EN
  period_meter #(.LINES(LINES), .PERIOD_W(PERIOD_W)) u_meter (
    .clk_i(clk_i), .global_rst(global_rst), .frame_opto_i(frame_opto_i),
    .frame_tick_o(frame_tick), .slot_len_o(slot_len), .period_o(period_o),
    .timeout_o(timeout)
  );
`else
  period_meter #(.LINES(LINES), .PERIOD_W(PERIOD_W)) u_meter (
    .clk_i(clk_i), .global_rst(global_rst), .frame_opto_i(frame_opto_i),
    .frame_tick_o(frame_tick), .slot_len_o(slot_len), .timeout_o(timeout)
  );
`endif

  // A zero slot length is stretched to one cycle so the sequence never stalls.
  assign slot_reload = ((slot_len == '0) ? PERIOD_W'(1) : slot_len) - PERIOD_W'(1);
  // Slot 0 right after a flush must not consume a line that is being discarded.
  assign fifo_empty  = (fifo_level_i == '0) | flush_q;

  // Next-state: FSM, slot sequencing, line_go decision and Pi handshake.
  always_comb begin
    state_d      = state_q;
    slot_timer_d = slot_timer_q;
    line_idx_d   = line_idx_q;
    decide_d     = 1'b0;
    case (state_q)
      IDLE:    state_d = frame_tick ? ARM : IDLE;
      ARM:     state_d = frame_tick ? RUN : ARM;
      RUN: begin
        if (frame_tick) state_d = RUN;
        else if (timeout) state_d = IDLE;
        else state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (frame_tick && (state_q != IDLE)) begin
      slot_timer_d = slot_reload;
      line_idx_d   = '0;
      decide_d     = 1'b1;
    end else if ((state_q == RUN) && (state_d == RUN)) begin
      if (slot_timer_q != '0) begin
        slot_timer_d = slot_timer_q - PERIOD_W'(1);
      end else if (line_idx_q != LAST_IDX) begin
        slot_timer_d = slot_reload;
        line_idx_d   = line_idx_q + IDX_W'(1);
        decide_d     = 1'b1;
      end else begin
        slot_timer_d = slot_timer_q;
      end
    end else begin
      slot_timer_d = slot_timer_q;
    end

    line_go_d = decide_q & ~fifo_empty & ~tlc_busy_i;
    flush_d   = frame_tick & (state_q == RUN) & (fifo_level_i != '0);

    if (frame_tick) frame_rst_d = 1'b1;
    else if (line_wr_i) frame_rst_d = 1'b0;
    else frame_rst_d = frame_rst_q;

    if (frame_tick) lines_written_d = '0;
    else if (line_wr_i && (lines_written_q != LW_FULL)) lines_written_d = lines_written_q + LW_W'(1);
    else lines_written_d = lines_written_q;

    busy_d  = (state_q != RUN) | (lines_written_q == LW_FULL) | (fifo_level_i > LVL_HI);
    blank_d = (state_d != RUN);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (global_rst) begin
      state_q         <= IDLE;
      slot_timer_q    <= '0;
      line_idx_q      <= '0;
      lines_written_q <= '0;
      decide_q        <= 1'b0;
      line_go_q       <= 1'b0;
      flush_q         <= 1'b0;
      frame_rst_q     <= 1'b0;
      busy_q          <= 1'b1;
      blank_q         <= 1'b1;
    end else begin
      state_q         <= state_d;
      slot_timer_q    <= slot_timer_d;
      line_idx_q      <= line_idx_d;
      lines_written_q <= lines_written_d;
      decide_q        <= decide_d;
      line_go_q       <= line_go_d;
      flush_q         <= flush_d;
      frame_rst_q     <= frame_rst_d;
      busy_q          <= busy_d;
      blank_q         <= blank_d;
    end
  end

`ifdef LINE_SCHED_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d, late_cnt_q, late_cnt_d;

  // Saturating decision-event counters; only global_rst clears them.
  always_comb begin
    if (decide_q && fifo_empty && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
    else underrun_cnt_d = underrun_cnt_q;
    if (decide_q && !fifo_empty && tlc_busy_i && (late_cnt_q != 16'hFFFF)) late_cnt_d = late_cnt_q + 16'd1;
    else late_cnt_d = late_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (global_rst) begin
      underrun_cnt_q <= 16'd0;
      late_cnt_q     <= 16'd0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      late_cnt_q     <= late_cnt_d;
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
  assign late_cnt_o     = late_cnt_q;
`endif

  assign line_go_o      = line_go_q;
  assign line_idx_o     = line_idx_q;
  assign blank_o        = blank_q;
  assign fifo_flush_o   = flush_q;
  assign frame_rst_o_pi = frame_rst_q;
  assign busy_o_pi      = busy_q;
endmodule

// File: tb/tb_line_scheduler.sv
// Self-checking bench for line_scheduler: revolution-level reference model with randomized levels/periods.
module tb_line_scheduler;
  localparam int LINES = 8, FIFO_LINES = 2, FIFO_DEPTH = 4, PERIOD_W = 12;
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int IDX_W = $clog2(LINES);
  localparam int PMAX  = (1 << PERIOD_W) - 1;

  logic clk = 1'b0;
  logic global_rst, frame_opto_i, line_wr_i, tlc_busy_i;
  logic [LVL_W-1:0] fifo_level_i;
  logic line_go_o, blank_o, fifo_flush_o, frame_rst_o_pi, busy_o_pi;
  logic [IDX_W-1:0] line_idx_o;
`ifdef LINE_SCHED_STATS_EN
  logic [15:0] underrun_cnt_o, late_cnt_o;
  logic [PERIOD_W-1:0] period_o;
`endif

  line_scheduler #(.LINES(LINES), .FIFO_LINES(FIFO_LINES), .FIFO_DEPTH(FIFO_DEPTH), .PERIOD_W(PERIOD_W)) dut (
    .clk_i(clk), .global_rst(global_rst), .frame_opto_i(frame_opto_i), .line_wr_i(line_wr_i),
    .fifo_level_i(fifo_level_i), .tlc_busy_i(tlc_busy_i), .line_go_o(line_go_o),
    .line_idx_o(line_idx_o), .blank_o(blank_o), .fifo_flush_o(fifo_flush_o),
    .frame_rst_o_pi(frame_rst_o_pi),
`ifdef LINE_SCHED_STATS_EN
    .underrun_cnt_o(underrun_cnt_o), .late_cnt_o(late_cnt_o), .period_o(period_o),
`endif
    .busy_o_pi(busy_o_pi)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int go_idx[$];
  int go_cyc[$];
  int flush_cnt = 0;

  // Model: 0 = waiting for first tick, 1 = armed, 2 = running.
  int m_state = 0;
  int m_interval = 0;
  int m_under = 0, m_late = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (line_go_o === 1'b1) begin
      go_idx.push_back(int'(line_idx_o));
      go_cyc.push_back(cyc);
    end
    if (fifo_flush_o === 1'b1) flush_cnt = flush_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One revolution: opto pulse at cycle 0, slot decisions expected at 4 + s*slot_len.
  task automatic run_rev(input int p, input int lvl, input int bslot, input int n_wr);
    bit was_run, run_after, flush;
    int slen, h, dec;
    int exp_s[$];
    was_run = (m_state == 2);
    m_state = (m_state == 0) ? 1 : 2;
    run_after = (m_state == 2);
    slen = m_interval / LINES;
    if (slen == 0) slen = 1;
    h = slen / 2;
    flush = was_run && (lvl > 0);
    go_idx.delete();
    go_cyc.delete();
    flush_cnt = 0;
    fifo_level_i = LVL_W'(lvl);
    for (int c = 0; c < p; c++) begin
      frame_opto_i = (c < 4);
      dec = 4 + bslot * slen;
      tlc_busy_i = run_after && (bslot >= 0) && (c - dec < h) && (dec - c < h);
      line_wr_i = (c >= 300) && ((c - 300) % 20 == 0) && ((c - 300) / 20 < n_wr);
      @(posedge clk);
      #1;
      if (c == 20) begin
        check("frame_rst_set", frame_rst_o_pi, 1);
        check("blank", blank_o, !run_after);
      end
      if (c == 250) check("busy_mid", busy_o_pi, (!run_after || lvl > 2));
      if (c == 330) check("frame_rst_clr", frame_rst_o_pi, (n_wr == 0));
      if (c == p - 5) check("busy_end", busy_o_pi, (!run_after || n_wr >= LINES || lvl > 2));
    end
    tlc_busy_i = 1'b0;
    line_wr_i = 1'b0;
    if (run_after) begin
      for (int s = 0; s < LINES; s++) begin
        if (4 + s * slen < p - 10) begin
          if (lvl == 0 || (s == 0 && flush)) m_under++;
          else if (s == bslot) m_late++;
          else exp_s.push_back(s);
        end
      end
    end
    check("go_count", go_idx.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < go_idx.size(); i++) begin
      check("go_idx", go_idx[i], exp_s[i]);
      if (i > 0) check("go_spacing", go_cyc[i] - go_cyc[i-1], (exp_s[i] - exp_s[i-1]) * slen);
    end
    check("flush_cnt", flush_cnt, flush ? 1 : 0);
`ifdef LINE_SCHED_STATS_EN
    check("underrun_cnt", underrun_cnt_o, m_under);
    check("late_cnt", late_cnt_o, m_late);
    if (run_after) check("period", period_o, m_interval);
`endif
    m_interval = p;
  endtask

  task automatic idle_wait(input int n);
    go_idx.delete();
    frame_opto_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("idle_go_count", go_idx.size(), 0);
    check("idle_blank", blank_o, 1);
    check("idle_busy", busy_o_pi, 1);
    m_state = 0;
    m_interval = (m_interval + n > PMAX) ? PMAX : m_interval + n;
  endtask

  initial begin
    global_rst = 1'b1;
    frame_opto_i = 1'b0;
    line_wr_i = 1'b0;
    tlc_busy_i = 1'b0;
    fifo_level_i = '0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_blank", blank_o, 1);
    check("rst_busy", busy_o_pi, 1);
    check("rst_line_go", line_go_o, 0);
    check("rst_flush", fifo_flush_o, 0);
    check("rst_frame_rst", frame_rst_o_pi, 0);
    check("rst_line_idx", line_idx_o, 0);
`ifdef LINE_SCHED_STATS_EN
    check("rst_underrun", underrun_cnt_o, 0);
    check("rst_late", late_cnt_o, 0);
`endif
    global_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    run_rev(800, 2, -1, 0);
    run_rev(800, 2, -1, 8);
    run_rev(800, 2, -1, 3);
    run_rev(800, 0, -1, 2);
    run_rev(800, 2, 3, 1);
    run_rev(450, 1, -1, 3);
    run_rev(800, 2, -1, 0);
    for (int r = 0; r < 6; r++) begin
      run_rev(780 + int'($urandom_range(0, 40)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 8)) - 1, int'($urandom_range(0, 10)));
    end
    idle_wait(4200);
    run_rev(800, 2, -1, 1);
    run_rev(800, 2, -1, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
